// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 16:1 select mux.
// It picks one requester per transfer, captures the mux word and hands it downstream through valid/ready.
module mux16_rr_arbiter #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [15:0]   req,
   input  logic [DW-1:0] mux_y,
   output logic [3:0]    sel,
   output logic [15:0]   gnt,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e        state_q;
   logic [3:0]    sel_q;
   logic [3:0]    ptr_q;
   logic [DW-1:0] out_data_q;
   logic          out_valid_q;

   logic [3:0]    sel_d;
   logic          req_any;

   // The winner is the first set request at or above ptr_q, wrapping past 15.
   always_comb begin
      logic       found;
      logic [3:0] idx;
      sel_d = ptr_q;
      found = 1'b0;
      idx   = ptr_q;
      for (int k = 0; k < 16; k++) begin
         idx = ptr_q + 4'(k);
         if (!found && req[idx]) begin
            sel_d = idx;
            found = 1'b1;
         end
      end
   end

   assign req_any = |req;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sel_q       <= 4'd0;
         ptr_q       <= 4'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_any) begin
                  sel_q   <= sel_d;
                  state_q <= S_XFER;
               end
            end
            S_XFER: begin
               // The grant is already committed; a dropped req does not cancel the capture.
               out_data_q  <= mux_y;
               out_valid_q <= 1'b1;
               ptr_q       <= sel_q + 4'd1;
               state_q     <= S_WAIT;
            end
            S_WAIT: begin
               if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
                  if (req_any) begin
                     sel_q   <= sel_d;
                     state_q <= S_XFER;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q     <= S_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign sel       = sel_q;
   assign gnt       = (state_q == S_XFER) ? (16'h0001 << sel_q) : 16'h0000;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter; the mux model returns DEAD_00xx where xx is the select.
module tb_mux16_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [31:0] mux_y;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mux16_rr_arbiter #(.DW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mux_y     (mux_y),
      .sel       (sel),
      .gnt       (gnt),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   assign mux_y = 32'hDEAD_0000 | {28'h0, sel};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req = 16'h0000;
      out_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 16'hFFFF;
      out_ready = 1'b1;
      step();
      step();
      checks++; if (sel !== 4'd0) begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
      checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL reset_gnt got %h exp 0000", gnt); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      rst_n = 1'b1;
      req = 16'h0000;
      out_ready = 1'b0;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_single();
      apply_reset();
      req = 16'h0020;
      step();
      checks++; if (sel !== 4'd5) begin errors++; $display("FAIL single_sel got %0d exp 5", sel); end
      checks++; if (gnt !== 16'h0020) begin errors++; $display("FAIL single_gnt got %h exp 0020", gnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b exp 0", out_valid); end
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'hDEAD_0005) begin errors++; $display("FAIL single_data got %h exp DEAD0005", out_data); end
      checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL single_gnt_off got %h exp 0000", gnt); end
      req = 16'h0000;
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_hs_valid got %b exp 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_hs_busy got %b exp 1->0", busy); end
      // ptr is now 6: with sources 0 and 5 requesting, source 0 comes first.
      req = 16'h0021;
      step();
      checks++; if (sel !== 4'd0) begin errors++; $display("FAIL single_ptr6_sel got %0d exp 0", sel); end
      checks++; if (gnt !== 16'h0001) begin errors++; $display("FAIL single_ptr6_gnt got %h exp 0001", gnt); end
      req = 16'h0000;
      step();
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_end_busy got %b exp 0", busy); end
   endtask

   task automatic test_full_contention();
      logic [3:0] e;
      apply_reset();
      req = 16'hFFFF;
      out_ready = 1'b1;
      for (int g = 0; g < 18; g++) begin
         e = 4'(g % 16);
         step();
         checks++; if (sel !== e) begin errors++; $display("FAIL full_sel[%0d] got %0d exp %0d", g, sel, e); end
         checks++; if (gnt !== (16'h0001 << e)) begin errors++; $display("FAIL full_gnt[%0d] got %h exp %h", g, gnt, 16'h0001 << e); end
         step();
         checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL full_gnt_gap[%0d] got %h exp 0000", g, gnt); end
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid[%0d] got %b exp 1", g, out_valid); end
         checks++; if (out_data !== (32'hDEAD_0000 | {28'h0, e})) begin errors++; $display("FAIL full_data[%0d] got %h exp %h", g, out_data, 32'hDEAD_0000 | {28'h0, e}); end
         if (g == 17) req = 16'h0000;
      end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_end_busy got %b exp 0", busy); end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_sel [4];
      exp_sel = '{4'd0, 4'd15, 4'd0, 4'd15};
      apply_reset();
      req = 16'h8001;
      out_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         step();
         checks++; if (sel !== exp_sel[g]) begin errors++; $display("FAIL fair_sel[%0d] got %0d exp %0d", g, sel, exp_sel[g]); end
         checks++; if (gnt !== (16'h0001 << exp_sel[g])) begin errors++; $display("FAIL fair_gnt[%0d] got %h exp %h", g, gnt, 16'h0001 << exp_sel[g]); end
         step();
         if (g == 3) req = 16'h0000;
      end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_end_busy got %b exp 0", busy); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      req = 16'h0008;
      out_ready = 1'b0;
      step();
      checks++; if (sel !== 4'd3) begin errors++; $display("FAIL bp_sel got %0d exp 3", sel); end
      checks++; if (gnt !== 16'h0008) begin errors++; $display("FAIL bp_gnt got %h exp 0008", gnt); end
      req = 16'h0080;
      for (int c = 0; c < 5; c++) begin
         step();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", c, out_valid); end
         checks++; if (out_data !== 32'hDEAD_0003) begin errors++; $display("FAIL bp_data[%0d] got %h exp DEAD0003", c, out_data); end
         checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL bp_gnt_hold[%0d] got %h exp 0000", c, gnt); end
         checks++; if (sel !== 4'd3) begin errors++; $display("FAIL bp_sel_hold[%0d] got %0d exp 3", c, sel); end
      end
      out_ready = 1'b1;
      step();
      checks++; if (sel !== 4'd7) begin errors++; $display("FAIL bp_next_sel got %0d exp 7", sel); end
      checks++; if (gnt !== 16'h0080) begin errors++; $display("FAIL bp_next_gnt got %h exp 0080", gnt); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_hs_valid got %b exp 0", out_valid); end
      req = 16'h0000;
      step();
      checks++; if (out_data !== 32'hDEAD_0007) begin errors++; $display("FAIL bp_next_data got %h exp DEAD0007", out_data); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_end_busy got %b exp 0", busy); end
   endtask

   task automatic test_reset_mid_transfer();
      apply_reset();
      req = 16'h0020;
      out_ready = 1'b1;
      step();
      req = 16'h0010;
      step();
      step();
      checks++; if (sel !== 4'd4) begin errors++; $display("FAIL rmid_pre_sel got %0d exp 4", sel); end
      checks++; if (gnt !== 16'h0010) begin errors++; $display("FAIL rmid_pre_gnt got %h exp 0010", gnt); end
      rst_n = 1'b0;
      req = 16'h0000;
      step();
      checks++; if (sel !== 4'd0) begin errors++; $display("FAIL rmid_sel got %0d exp 0", sel); end
      checks++; if (gnt !== 16'h0000) begin errors++; $display("FAIL rmid_gnt got %h exp 0000", gnt); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rmid_data got %h exp 0", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
      rst_n = 1'b1;
      req = 16'h0044;
      step();
      checks++; if (sel !== 4'd2) begin errors++; $display("FAIL rmid_after_sel got %0d exp 2", sel); end
      checks++; if (gnt !== 16'h0004) begin errors++; $display("FAIL rmid_after_gnt got %h exp 0004", gnt); end
      req = 16'h0000;
      step();
      checks++; if (out_data !== 32'hDEAD_0002) begin errors++; $display("FAIL rmid_after_data got %h exp DEAD0002", out_data); end
      step();
   endtask

   task automatic test_dropped_request();
      apply_reset();
      req = 16'h0200;
      step();
      req = 16'h0000;
      checks++; if (sel !== 4'd9) begin errors++; $display("FAIL drop_sel got %0d exp 9", sel); end
      checks++; if (gnt !== 16'h0200) begin errors++; $display("FAIL drop_gnt got %h exp 0200", gnt); end
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drop_valid got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'hDEAD_0009) begin errors++; $display("FAIL drop_data got %h exp DEAD0009", out_data); end
      out_ready = 1'b1;
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b exp 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_end_valid got %b exp 0", out_valid); end
   endtask

   initial begin
      rst_n = 1'b0;
      req = 16'h0000;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_full_contention();
      test_fairness();
      test_backpressure();
      test_reset_mid_transfer();
      test_dropped_request();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
